// File: rtl/alu_pkg.sv
// alu_pkg -- shared widths, mode codes and solver state encoding for alu_solver.
// Rev 1.0
`default_nettype none

package alu_pkg;

  localparam int OP_W   = 4;
  localparam int RES_W  = 9;
  localparam int DVSR_W = 5;
  localparam int REM_W  = 6;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_MUL = 2'b10;
  localparam logic [1:0] MODE_LIN = 2'b11;

  localparam logic [3:0] DIV_ITER_LAST = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } solver_state_t;

  function automatic logic [RES_W-1:0] zext_op(input logic [OP_W-1:0] v);
    return {{(RES_W-OP_W){1'b0}}, v};
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_solver_div.sv
// alu_solver_div -- 9-bit by 5-bit restoring divider, one quotient bit per step.
// Rev 1.0
`default_nettype none

module alu_solver_div
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              last,
  input  logic [RES_W-1:0]  dividend,
  input  logic [DVSR_W-1:0] divisor,
  output logic [RES_W-1:0]  quo,
  output logic [REM_W-1:0]  rem
);

  logic [RES_W-1:0]  r_shift;
  logic [RES_W-1:0]  r_quo;
  logic [REM_W-1:0]  r_rem;
  logic [DVSR_W-1:0] r_divisor;

  logic [REM_W-1:0]  w_trial;
  logic              w_fits;
  logic [REM_W-1:0]  w_rem_nxt;
  logic [RES_W-1:0]  w_quo_nxt;

  // Remainder stays below the divisor (max 30), so its top bit is always free for the shift-in.
  assign w_trial   = {r_rem[REM_W-2:0], r_shift[RES_W-1]};
  assign w_fits    = (w_trial >= {1'b0, r_divisor});
  assign w_rem_nxt = w_fits ? (w_trial - {1'b0, r_divisor}) : w_trial;
  assign w_quo_nxt = {r_quo[RES_W-2:0], w_fits};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
    end else if (load) begin
      r_shift   <= dividend;
      r_quo     <= '0;
      r_rem     <= '0;
      r_divisor <= divisor;
    end else if (step) begin
      r_shift   <= {r_shift[RES_W-2:0], 1'b0};
      r_quo     <= w_quo_nxt;
      r_rem     <= w_rem_nxt;
    end
  end

  // On the final step the finished result is presented before it is registered.
  assign quo = (step && last) ? w_quo_nxt : r_quo;
  assign rem = (step && last) ? w_rem_nxt : r_rem;

endmodule

`default_nettype wire

// File: rtl/alu_solver.sv
// alu_solver -- recovers the unknown 4-bit ALU operand from a 9-bit result and mode.
// Rev 1.0
`default_nettype none

module alu_solver
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  input  logic [RES_W-1:0] r,
  output logic             busy,
  output logic             done,
  output logic [OP_W-1:0]  u,
  output logic             exact,
  output logic             div0
);

  solver_state_t r_state;
  solver_state_t w_state_nxt;

  logic [1:0]        r_mode;
  logic [OP_W-1:0]   r_a;
  logic [OP_W-1:0]   r_b;
  logic [RES_W-1:0]  r_r;
  logic [3:0]        r_cnt;
  logic [OP_W-1:0]   r_u;
  logic              r_exact;
  logic              r_div0;

  logic              w_accept;
  logic [RES_W-1:0]  w_diff_add;
  logic [RES_W-1:0]  w_diff_sub;
  logic [RES_W-1:0]  w_dividend;
  logic [DVSR_W-1:0] w_divisor;
  logic              w_div_zero;
  logic              w_r_lt_b;
  logic              w_use_div;
  logic              w_div_load;
  logic              w_div_step;
  logic              w_div_last;
  logic [RES_W-1:0]  w_quo;
  logic [REM_W-1:0]  w_rem;

  assign w_accept   = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
  assign w_diff_add = r_r - zext_op(r_a);
  assign w_diff_sub = zext_op(r_a) - r_r;
  assign w_r_lt_b   = (r_r < zext_op(r_b));
  assign w_divisor  = (r_mode == MODE_LIN) ? {r_a, 1'b0} : {1'b0, r_a};
  assign w_dividend = (r_mode == MODE_LIN) ? (r_r - zext_op(r_b)) : r_r;
  assign w_div_zero = (w_divisor == '0);
  // A zero divisor wins over r<B so div0 always flags A=0 in the multiply modes.
  assign w_use_div  = r_mode[1] && !w_div_zero && !((r_mode == MODE_LIN) && w_r_lt_b);
  assign w_div_load = (r_state == ST_PREP) && w_use_div;
  assign w_div_step = (r_state == ST_DIV);
  assign w_div_last = (r_cnt == 4'd0);

  alu_solver_div u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_div_load),
    .step     (w_div_step),
    .last     (w_div_last),
    .dividend (w_dividend),
    .divisor  (w_divisor),
    .quo      (w_quo),
    .rem      (w_rem)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_PREP;
      ST_PREP: w_state_nxt = w_use_div ? ST_DIV : ST_DONE;
      ST_DIV:  if (w_div_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = w_accept ? ST_PREP : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == ST_PREP) || (r_state == ST_DIV);
    done = (r_state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      r_u     <= '0;
      r_exact <= 1'b0;
      r_div0  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mode  <= mode;
        r_a     <= a;
        r_b     <= b;
        r_r     <= r;
        r_u     <= '0;
        r_exact <= 1'b0;
        r_div0  <= 1'b0;
      end
      case (r_state)
        ST_PREP: begin
          r_cnt <= DIV_ITER_LAST;
          case (r_mode)
            MODE_ADD: begin
              r_u     <= w_diff_add[OP_W-1:0];
              r_exact <= (r_r >= zext_op(r_a)) && (w_diff_add < RES_W'(16));
            end
            MODE_SUB: begin
              r_u     <= w_diff_sub[OP_W-1:0];
              r_exact <= (w_diff_sub < RES_W'(16));
            end
            default: if (w_div_zero) r_div0 <= 1'b1;
          endcase
        end
        ST_DIV: begin
          r_cnt <= r_cnt - 4'd1;
          if (w_div_last) begin
            r_u     <= w_quo[OP_W-1:0];
            r_exact <= (w_rem == '0) && (w_quo < RES_W'(16));
          end
        end
        default: ;
      endcase
    end
  end

  assign u     = r_u;
  assign exact = r_exact;
  assign div0  = r_div0;

endmodule

`default_nettype wire

// File: tb/tb_alu_solver.sv
// tb_alu_solver -- scoreboard bench for alu_solver: latency, results, ignored start, mid-divide reset.
// Rev 1.0
`default_nettype none

module tb_alu_solver;
  import alu_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [1:0]       mode;
  logic [OP_W-1:0]  a;
  logic [OP_W-1:0]  b;
  logic [RES_W-1:0] r;
  logic             busy;
  logic             done;
  logic [OP_W-1:0]  u;
  logic             exact;
  logic             div0;

  typedef struct {
    int u;
    int exact;
    int div0;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  alu_solver dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .a     (a),
    .b     (b),
    .r     (r),
    .busy  (busy),
    .done  (done),
    .u     (u),
    .exact (exact),
    .div0  (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    if (obs != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference straight from the operation definitions, using integer division.
  function automatic exp_t model(input int m, input int av, input int bv, input int rv);
    exp_t e;
    int d;
    int q;
    int rm;
    e = '{u: 0, exact: 0, div0: 0, lat: 2};
    case (m)
      0: begin
        d = (rv - av + 512) % 512;
        e.u = d % 16;
        e.exact = ((rv >= av) && (d < 16)) ? 1 : 0;
      end
      1: begin
        d = (av - rv + 512) % 512;
        e.u = d % 16;
        e.exact = (d < 16) ? 1 : 0;
      end
      default: begin
        if (av == 0) begin
          e.div0 = 1;
        end else if (m == 3 && rv < bv) begin
          e.lat = 2;
        end else begin
          d  = (m == 3) ? 2 * av : av;
          q  = ((m == 3) ? rv - bv : rv) / d;
          rm = ((m == 3) ? rv - bv : rv) % d;
          e.u = q % 16;
          e.exact = ((rm == 0) && (q < 16)) ? 1 : 0;
          e.lat = 11;
        end
      end
    endcase
    return e;
  endfunction

  // Called at a negedge in IDLE or DONE; returns at the negedge of the DONE cycle.
  task automatic issue(input int m, input int av, input int bv, input int rv,
                       input bit disturb, input string tag);
    exp_t e;
    int n;
    mode  = 2'(m);
    a     = 4'(av);
    b     = 4'(bv);
    r     = 9'(rv);
    start = 1'b1;
    exp_q.push_back(model(m, av, bv, rv));
    @(negedge clk);
    n     = 1;
    start = 1'b0;
    check({tag, ".busy1"}, int'(busy), 1);
    while (done !== 1'b1 && n < 20) begin
      if (disturb && n == 3) begin
        mode  = MODE_ADD;
        a     = 4'd1;
        b     = 4'd9;
        r     = 9'd2;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    e = exp_q.pop_front();
    check({tag, ".lat"}, n, e.lat);
    check({tag, ".busy_done"}, int'(busy), 0);
    check({tag, ".u"}, int'(u), e.u);
    check({tag, ".exact"}, int'(exact), e.exact);
    check({tag, ".div0"}, int'(div0), e.div0);
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0;
    start = 1'b0;
    mode  = '0;
    a     = '0;
    b     = '0;
    r     = '0;
    repeat (3) @(negedge clk);
    check("rst.busy", int'(busy), 0);
    check("rst.done", int'(done), 0);
    check("rst.u", int'(u), 0);
    check("rst.exact", int'(exact), 0);
    check("rst.div0", int'(div0), 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(0, 5, 0, 12, 1'b0, "add_ok");
    @(negedge clk);
    issue(0, 5, 0, 3, 1'b0, "add_neg");
    issue(1, 3, 0, 9'h1FE, 1'b0, "sub_ok");
    issue(1, 3, 0, 9'h1E0, 1'b0, "sub_big");
    @(negedge clk);
    issue(2, 6, 0, 42, 1'b0, "mul_ok");
    issue(2, 6, 0, 43, 1'b0, "mul_rem");
    issue(2, 1, 0, 200, 1'b0, "mul_q16");
    issue(3, 4, 3, 75, 1'b0, "lin_ok");
    issue(3, 4, 3, 2, 1'b0, "lin_rltb");
    issue(2, 0, 0, 0, 1'b0, "mul_div0");
    issue(3, 0, 5, 100, 1'b0, "lin_div0");
    for (int i = 0; i < 8; i++) begin
      issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 511)), 1'b0, "rand");
    end
    @(negedge clk);
    issue(2, 6, 0, 42, 1'b1, "ignore_start");
    @(negedge clk);

    // Abort a divide with reset in cycle T+5.
    mode  = MODE_MUL;
    a     = 4'd6;
    r     = 9'd42;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst.busy", int'(busy), 0);
    check("midrst.done", int'(done), 0);
    check("midrst.u", int'(u), 0);
    check("midrst.exact", int'(exact), 0);
    check("midrst.div0", int'(div0), 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("midrst.no_done", pulses, 0);

    issue(3, 4, 3, 75, 1'b0, "post_rst");
    @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_solver.md
# alu_solver

Inverse-operation unit for the 4-bit ALU. Given a 9-bit ALU result, the mode that produced it, and the known operands, it recovers the 4-bit unknown operand: B for modes 0–2, X for mode 3. It also reports whether an exact 4-bit solution exists. It sits beside the ALU as a checker/solver and uses a multi-cycle restoring divider for the multiply modes.

## Interface
- No parameters. All widths are fixed by the ALU: 4-bit operands, 9-bit result.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: request; accepted only when `busy`=0.
- `mode` in 2: 00 add, 01 sub, 10 mul, 11 2·A·X+B.
- `a` in 4: known operand A.
- `b` in 4: known operand B; used only in mode 11.
- `r` in 9: ALU result to invert.
- `busy` out 1: high from the cycle after acceptance until the result is ready.
- `done` out 1: one-cycle pulse; result outputs are valid from this cycle on.
- `u` out 4: recovered unknown operand.
- `exact` out 1: 1 iff `u` reproduces `r` exactly under `mode`.
- `div0` out 1: mode 10 with A=0, or mode 11 with A=0.

## Operation
- States:
  - IDLE: wait for a request.
  - PREP: capture-derived setup.
  - DIV: 9 iterations of the divider.
  - DONE: 1 cycle, `done`=1.
- IDLE/DONE with `start`=1: register mode, a, b, r, then go to PREP. `start` while `busy`=1 is ignored. Captured operands are immune to later input changes.
- PREP, all arithmetic mod 512:
  - mode 00: d = r − A; `u`=d[3:0]; `exact` = (r ≥ A) && (d < 16). Go to DONE.
  - mode 01: d = (A − r) mod 512; `u`=d[3:0]; `exact` = (d < 16). Go to DONE.
  - mode 10: dividend = r, divisor = {1'b0,A}.
  - mode 11: divisor = 2·A (5 bits). If r < B: `u`=0, `exact`=0, go to DONE. Otherwise dividend = r − B.
  - Divisor 0 (modes 10/11): `u`=0, `exact`=0, `div0`=1, go to DONE.
  - Otherwise go to DIV with counter = 8.
- DIV: restoring, MSB first, one quotient bit per cycle. Partial remainder is 6 bits; quotient is 9 bits. After the counter=0 iteration:
  - `u` = q[3:0]
  - `exact` = (rem==0) && (q < 16)
  - go to DONE.
- DONE: `done`=1 for one cycle, then IDLE unless a new `start` is accepted.
- `u`/`exact`/`div0` hold their last values until the next result load. All three are cleared at acceptance of a new request.

## Timing
- Request accepted at the edge ending cycle T.
- Modes 00/01, divisor-zero, and r<B: `busy`=1 in T+1; `done`=1 in T+2.
- Divide path: `busy`=1 in T+1..T+10; `done`=1 in T+11.
- `busy`=0 in the DONE cycle. Back-to-back: `start` in the DONE cycle is accepted.
- Reset (`rst_n`=0 at an edge, in any state including mid-DIV) sets:
  - state IDLE
  - `busy`=0, `done`=0, `u`=0, `exact`=0, `div0`=0
  - divider registers 0
- Reset has priority over `start`.

## Structure
- Package `alu_pkg`:
  - mode constants MODE_ADD/SUB/MUL/LIN = 2'b00..2'b11
  - width constants OP_W=4, RES_W=9
  - solver state enum
- Sub-module `alu_solver_div`: 9-bit ÷ 5-bit restoring divider with load/step/last controls, quotient, and remainder. The FSM and PREP arithmetic stay in the top module.
- Expected size: ~200 lines of RTL total.

## Test plan
- Mode 00, A=5, r=12 → u=7, exact=1, done in T+2. Same with r=3 → exact=0.
- Mode 01, A=3, r=9'h1FE (3−5) → u=5, exact=1. Same with r=9'h1E0 → exact=0.
- Mode 10, A=6, r=42 → u=7, exact=1, done exactly in T+11. Same with r=43 → u=7, exact=0. Same with A=1, r=200 → exact=0 (q ≥ 16).
- Mode 11, A=4, B=3, r=75 → u=9, exact=1. Same with r=2 → u=0, exact=0, done in T+2.
- Mode 10, A=0, r=0 → div0=1, exact=0, u=0, done in T+2.
- Second `start` with different operands during DIV → ignored; first result unchanged. `rst_n`=0 at T+5 of a divide → busy=0 and all outputs 0 in T+6, no `done` pulse. `start` in a DONE cycle → accepted; next done as per its mode.
